// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier scheduler: FSM state encoding,
// default parameters and a small index-wrap helper.
package booth_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DW      = 16;
    localparam int DEF_TIMEOUT = 40;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        RESP      = 3'd4
    } state_e;

    // Next round-robin slot after 'cur', wrapping at 'n'.
    function automatic int nextIndex(input int cur, input int n);
        return (cur >= n - 1) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin one-hot arbiter: the search starts at ptr_i and wraps, the
// first asserted request wins. Purely combinational.
module rr_arb #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [N-1:0]   grant_onehot_o,
    output logic [IDW-1:0] grant_id_o,
    output logic           any_o
);

    int             pos;
    logic [IDW-1:0] idx;

    always_comb begin
        grant_onehot_o = '0;
        grant_id_o     = '0;
        any_o          = 1'b0;
        pos            = 0;
        idx            = '0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = IDW'(pos);
            if (!any_o && req_i[idx]) begin
                any_o               = 1'b1;
                grant_id_o          = idx;
                grant_onehot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/booth_mul_sched.sv
// Shares one signed Booth multiplier among NUM_REQ requesters: round-robin
// grant, operand capture, start/busy handshake, product return and timeout.
module booth_mul_sched
    import booth_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ*DW-1:0] x_in_i,
    input  logic [NUM_REQ*DW-1:0] y_in_i,
    output logic [NUM_REQ-1:0]    done_o,
    output logic [2*DW-1:0]       z_out_o,
    output logic                  err_o,
    output logic                  mul_start_o,
    output logic [DW-1:0]         mul_x_o,
    output logic [DW-1:0]         mul_y_o,
    input  logic                  mul_busy_i,
    input  logic [2*DW-1:0]       mul_z_i
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int TW  = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [NUM_REQ-1:0]   idOh_q, idOh_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [DW-1:0]        opX_q, opX_d;
    logic [DW-1:0]        opY_q, opY_d;
    logic [2*DW-1:0]      z_q, z_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 err_q, err_d;

    logic [NUM_REQ-1:0]   arbOh;
    logic [IDW-1:0]       arbId;
    logic                 arbAny;
    logic                 canGrant;
    logic                 timedOut;
    logic [DW-1:0]        xArr [NUM_REQ];
    logic [DW-1:0]        yArr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
        assign xArr[g] = x_in_i[g*DW +: DW];
        assign yArr[g] = y_in_i[g*DW +: DW];
    end

    rr_arb #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) uArb (
        .req_i          (req_i),
        .ptr_i          (ptr_q),
        .grant_onehot_o (arbOh),
        .grant_id_o     (arbId),
        .any_o          (arbAny)
    );

    // A new operation may only start once the multiplier is idle, so a
    // multiplier still finishing an aborted job is never restarted early.
    assign canGrant = arbAny && !mul_busy_i;
    assign timedOut = (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (canGrant) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (timedOut) begin
                    state_d = RESP;
                end else if (mul_busy_i) begin
                    state_d = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                if (!mul_busy_i || timedOut) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next-state: operand capture, timer, product/done/err pulses.
    // A completed product takes priority over a timeout hitting the same cycle.
    always_comb begin
        ptr_d   = ptr_q;
        id_d    = id_q;
        idOh_d  = idOh_q;
        timer_d = timer_q;
        opX_d   = opX_q;
        opY_d   = opY_q;
        z_d     = z_q;
        done_d  = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (canGrant) begin
                    id_d   = arbId;
                    idOh_d = arbOh;
                    opX_d  = xArr[arbId];
                    opY_d  = yArr[arbId];
                end
            end
            ISSUE: begin
                timer_d = '0;
            end
            WAIT_RISE: begin
                if (timedOut) begin
                    z_d    = '0;
                    done_d = idOh_q;
                    err_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            WAIT_FALL: begin
                if (!mul_busy_i) begin
                    z_d    = mul_z_i;
                    done_d = idOh_q;
                end else if (timedOut) begin
                    z_d    = '0;
                    done_d = idOh_q;
                    err_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                ptr_d = IDW'(nextIndex(int'(id_q), NUM_REQ));
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            id_q    <= '0;
            idOh_q  <= '0;
            timer_q <= '0;
            opX_q   <= '0;
            opY_q   <= '0;
            z_q     <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            idOh_q  <= idOh_d;
            timer_q <= timer_d;
            opX_q   <= opX_d;
            opY_q   <= opY_d;
            z_q     <= z_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        mul_start_o = (state_q == ISSUE);
        mul_x_o     = opX_q;
        mul_y_o     = opY_q;
        z_out_o     = z_q;
        done_o      = done_q;
        err_o       = err_q;
    end

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched with a behavioural multiplier that holds
// busy for 17 cycles (or never raises it when noBusy is set).
module tb_booth_mul_sched;

    logic        clk;
    logic        rstN;
    logic [3:0]  req;
    logic [63:0] xIn;
    logic [63:0] yIn;
    logic [3:0]  done;
    logic [31:0] zOut;
    logic        err;
    logic        mulStart;
    logic [15:0] mulX;
    logic [15:0] mulY;
    logic        mulBusy;
    logic [31:0] mulZ;

    logic               noBusy;
    int                 busyCnt;
    logic signed [31:0] prod;
    int                 startCount;
    int                 testsRun;
    int                 testsFailed;

    booth_mul_sched #(
        .NUM_REQ (4),
        .DW      (16),
        .TIMEOUT (40)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .req_i       (req),
        .x_in_i      (xIn),
        .y_in_i      (yIn),
        .done_o      (done),
        .z_out_o     (zOut),
        .err_o       (err),
        .mul_start_o (mulStart),
        .mul_x_o     (mulX),
        .mul_y_o     (mulY),
        .mul_busy_i  (mulBusy),
        .mul_z_i     (mulZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: busy rises the cycle after start, stays high
    // 17 cycles, and the product is valid when busy falls.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mulBusy <= 1'b0;
            busyCnt <= 0;
            prod    <= '0;
            mulZ    <= '0;
        end else if (mulStart && !noBusy) begin
            mulBusy <= 1'b1;
            busyCnt <= 17;
            prod    <= $signed(mulX) * $signed(mulY);
        end else if (mulBusy) begin
            if (busyCnt == 1) begin
                mulBusy <= 1'b0;
                mulZ    <= prod;
            end
            busyCnt <= busyCnt - 1;
        end
    end

    always @(posedge clk) begin
        if (mulStart) begin
            startCount <= startCount + 1;
        end
    end

    task automatic setOps(input int i, input logic [15:0] x, input logic [15:0] y);
        xIn[i*16 +: 16] = x;
        yIn[i*16 +: 16] = y;
    endtask

    task automatic waitDone(input int budget, output int cycles, output logic [3:0] seen);
        cycles = 0;
        seen   = '0;
        while (cycles < budget && seen == 4'b0000) begin
            @(posedge clk);
            #1;
            cycles++;
            seen = done;
        end
    endtask

    task automatic waitStart(input int budget, output logic seen);
        int n;
        n    = 0;
        seen = 1'b0;
        while (n < budget && !seen) begin
            @(posedge clk);
            #1;
            n++;
            seen = mulStart;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 1'b0;
        req  = '0;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0; req = '0; xIn = '0; yIn = '0; noBusy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        testsRun++; if (done !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected %b", done, 4'b0000); end
        testsRun++; if (zOut !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_z: got %h expected %h", zOut, 32'h0); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        testsRun++; if (mulStart !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_start: got %b expected 0", mulStart); end
        testsRun++; if (mulX !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_mulx: got %h expected 0000", mulX); end
        testsRun++; if (mulY !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_muly: got %h expected 0000", mulY); end
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        testsRun++; if (mulStart !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_no_start: got %b expected 0", mulStart); end
    endtask

    task automatic test_single();
        int         cycles;
        logic [3:0] seen;
        int         s0;
        @(negedge clk);
        setOps(0, 16'd3, 16'hFFFB);
        req = 4'b0001;
        s0  = startCount;
        waitDone(60, cycles, seen);
        testsRun++; if (seen !== 4'b0001) begin testsFailed++; $display("[TB] FAIL single_done: got %b expected %b", seen, 4'b0001); end
        // Latency counts the IDLE cycle in which req is presented as cycle 1.
        testsRun++; if (cycles + 1 != 21) begin testsFailed++; $display("[TB] FAIL single_latency: got %0d expected 21", cycles + 1); end
        testsRun++; if (zOut !== 32'hFFFFFFF1) begin testsFailed++; $display("[TB] FAIL single_z: got %h expected %h", zOut, 32'hFFFFFFF1); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_err: got %b expected 0", err); end
        @(negedge clk);
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        testsRun++; if (done !== 4'b0000) begin testsFailed++; $display("[TB] FAIL single_pulse_width: got %b expected 0000", done); end
        testsRun++; if (startCount - s0 != 1) begin testsFailed++; $display("[TB] FAIL single_start_count: got %0d expected 1", startCount - s0); end
        testsRun++; if (zOut !== 32'hFFFFFFF1) begin testsFailed++; $display("[TB] FAIL single_z_hold: got %h expected %h", zOut, 32'hFFFFFFF1); end
    endtask

    task automatic test_all_four();
        logic [3:0]  expDone [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [31:0] expZ    [5] = '{32'd49, 32'd1, 32'h40000000, 32'd0, 32'd49};
        int          cycles;
        logic [3:0]  seen;
        doReset();
        setOps(0, 16'd7, 16'd7);
        setOps(1, 16'hFFFF, 16'hFFFF);
        setOps(2, 16'h8000, 16'h8000);
        setOps(3, 16'd0, 16'd1234);
        @(negedge clk);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            waitDone(60, cycles, seen);
            testsRun++; if (seen !== expDone[i]) begin testsFailed++; $display("[TB] FAIL rr_order_%0d: got %b expected %b", i, seen, expDone[i]); end
            testsRun++; if (zOut !== expZ[i]) begin testsFailed++; $display("[TB] FAIL rr_product_%0d: got %h expected %h", i, zOut, expZ[i]); end
        end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_req_drop();
        int         cycles;
        logic [3:0] seen;
        logic       started;
        int         s0;
        @(negedge clk);
        setOps(2, 16'd100, 16'hFFFE);
        req = 4'b0100;
        s0  = startCount;
        waitStart(10, started);
        testsRun++; if (started !== 1'b1) begin testsFailed++; $display("[TB] FAIL drop_started: got %b expected 1", started); end
        repeat (5) @(negedge clk);
        req = '0;
        waitDone(60, cycles, seen);
        testsRun++; if (seen !== 4'b0100) begin testsFailed++; $display("[TB] FAIL drop_done: got %b expected %b", seen, 4'b0100); end
        testsRun++; if (zOut !== 32'hFFFFFF38) begin testsFailed++; $display("[TB] FAIL drop_z: got %h expected %h", zOut, 32'hFFFFFF38); end
        repeat (4) @(posedge clk);
        #1;
        testsRun++; if (startCount - s0 != 1) begin testsFailed++; $display("[TB] FAIL drop_start_count: got %0d expected 1", startCount - s0); end
    endtask

    task automatic test_operand_change();
        int         cycles;
        logic [3:0] seen;
        logic       started;
        @(negedge clk);
        setOps(3, 16'd25, 16'hFFFC);
        req = 4'b1000;
        waitStart(10, started);
        testsRun++; if (started !== 1'b1) begin testsFailed++; $display("[TB] FAIL opchg_started: got %b expected 1", started); end
        @(negedge clk);
        setOps(3, 16'd1000, 16'd1000);
        @(posedge clk);
        #1;
        testsRun++; if (mulX !== 16'd25) begin testsFailed++; $display("[TB] FAIL opchg_mulx: got %h expected %h", mulX, 16'd25); end
        testsRun++; if (mulY !== 16'hFFFC) begin testsFailed++; $display("[TB] FAIL opchg_muly: got %h expected %h", mulY, 16'hFFFC); end
        waitDone(60, cycles, seen);
        testsRun++; if (seen !== 4'b1000) begin testsFailed++; $display("[TB] FAIL opchg_done: got %b expected %b", seen, 4'b1000); end
        testsRun++; if (zOut !== 32'hFFFFFF9C) begin testsFailed++; $display("[TB] FAIL opchg_z: got %h expected %h", zOut, 32'hFFFFFF9C); end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_timeout();
        int         cycles;
        logic [3:0] seen;
        logic       started;
        @(negedge clk);
        noBusy = 1'b1;
        setOps(1, 16'd5, 16'd6);
        req = 4'b0010;
        waitStart(10, started);
        testsRun++; if (started !== 1'b1) begin testsFailed++; $display("[TB] FAIL tmo_started: got %b expected 1", started); end
        @(posedge clk);
        waitDone(100, cycles, seen);
        testsRun++; if (seen !== 4'b0010) begin testsFailed++; $display("[TB] FAIL tmo_done: got %b expected %b", seen, 4'b0010); end
        testsRun++; if (cycles != 40) begin testsFailed++; $display("[TB] FAIL tmo_cycles: got %0d expected 40", cycles); end
        testsRun++; if (err !== 1'b1) begin testsFailed++; $display("[TB] FAIL tmo_err: got %b expected 1", err); end
        testsRun++; if (zOut !== 32'h0) begin testsFailed++; $display("[TB] FAIL tmo_z: got %h expected %h", zOut, 32'h0); end
        @(negedge clk);
        req    = '0;
        noBusy = 1'b0;
        @(posedge clk);
        #1;
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL tmo_err_pulse: got %b expected 0", err); end
        @(negedge clk);
        setOps(2, 16'hFFF9, 16'd9);
        req = 4'b0100;
        waitDone(60, cycles, seen);
        testsRun++; if (seen !== 4'b0100) begin testsFailed++; $display("[TB] FAIL tmo_next_done: got %b expected %b", seen, 4'b0100); end
        testsRun++; if (zOut !== 32'hFFFFFFC1) begin testsFailed++; $display("[TB] FAIL tmo_next_z: got %h expected %h", zOut, 32'hFFFFFFC1); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL tmo_next_err: got %b expected 0", err); end
        @(negedge clk);
        req = '0;
    endtask

    task automatic test_reset_mid();
        int         cycles;
        logic [3:0] seen;
        logic [3:0] doneAcc;
        logic       started;
        @(negedge clk);
        setOps(3, 16'd2, 16'd3);
        req = 4'b1000;
        waitStart(10, started);
        testsRun++; if (started !== 1'b1) begin testsFailed++; $display("[TB] FAIL rstmid_started: got %b expected 1", started); end
        repeat (6) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        req  = '0;
        #1;
        testsRun++; if (done !== 4'b0000) begin testsFailed++; $display("[TB] FAIL rstmid_done: got %b expected 0000", done); end
        testsRun++; if (zOut !== 32'h0) begin testsFailed++; $display("[TB] FAIL rstmid_z: got %h expected %h", zOut, 32'h0); end
        testsRun++; if (err !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_err: got %b expected 0", err); end
        testsRun++; if (mulStart !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstmid_start: got %b expected 0", mulStart); end
        testsRun++; if (mulX !== 16'h0 || mulY !== 16'h0) begin testsFailed++; $display("[TB] FAIL rstmid_ops: got %h/%h expected 0000/0000", mulX, mulY); end
        @(negedge clk);
        rstN    = 1'b1;
        doneAcc = '0;
        repeat (4) begin
            @(posedge clk);
            #1;
            doneAcc = doneAcc | done;
        end
        testsRun++; if (doneAcc !== 4'b0000) begin testsFailed++; $display("[TB] FAIL rstmid_no_done: got %b expected 0000", doneAcc); end
        @(negedge clk);
        setOps(0, 16'd11, 16'd11);
        req = 4'b1001;
        waitDone(60, cycles, seen);
        testsRun++; if (seen !== 4'b0001) begin testsFailed++; $display("[TB] FAIL rstmid_ptr0: got %b expected %b", seen, 4'b0001); end
        testsRun++; if (zOut !== 32'd121) begin testsFailed++; $display("[TB] FAIL rstmid_z121: got %h expected %h", zOut, 32'd121); end
        @(negedge clk);
        req = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        startCount  = 0;
        test_reset();
        test_single();
        test_all_four();
        test_req_drop();
        test_operand_change();
        test_timeout();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
